// File: rtl/exec_wb_stage.sv
// Single-issue execute/writeback stage: reads two operands, computes an ALU or
// iterative shift-add multiply result, and issues one register-file write per instruction.
module exec_wb_stage #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 3,
  parameter int MUL_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [ADDR_W-1:0] rd0_addr,
  output logic [ADDR_W-1:0] rd1_addr,
  input  logic [DATA_W-1:0] rd0_data,
  input  logic [DATA_W-1:0] rd1_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic [15:0]       retired
);

  localparam int CNT_W = $clog2(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_MUL, OP_ADDI
  } op_t;

  state_t state, state_next;

  logic [15:0]       instr_q;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_step;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] imm_ext;
  logic [CNT_W-1:0]  mul_cnt;
  op_t               op;
  logic [ADDR_W-1:0] rd;

  assign op      = op_t'(instr_q[15:13]);
  assign rd      = instr_q[12:10];
  assign imm_ext = {{(DATA_W-4){instr_q[3]}}, instr_q[3:0]};

  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign RegWrite    = (state == WB);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (instr_valid) state_next = READ;
      READ: state_next = (op == OP_MUL) ? EXEC : WB;
      EXEC: if (mul_cnt == CNT_LAST) state_next = WB;
      WB:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle ops are evaluated straight off the combinational read ports.
  always_comb begin
    alu_result = '0;
    case (op)
      OP_ADD:  alu_result = rd0_data + rd1_data;
      OP_SUB:  alu_result = rd0_data - rd1_data;
      OP_AND:  alu_result = rd0_data & rd1_data;
      OP_OR:   alu_result = rd0_data | rd1_data;
      OP_XOR:  alu_result = rd0_data ^ rd1_data;
      OP_SLL:  alu_result = rd0_data << rd1_data[3:0];
      OP_ADDI: alu_result = rd0_data + imm_ext;
      default: alu_result = '0;
    endcase
  end

  assign acc_step = acc + (mplier[0] ? mcand : '0);

  // wr_addr/wr_data only change on entry to WB so they hold between writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q  <= '0;
      rd0_addr <= '0;
      rd1_addr <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      mul_cnt  <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      retired  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            instr_q  <= instr;
            rd0_addr <= instr[9:7];
            rd1_addr <= instr[6:4];
          end
        end
        READ: begin
          if (op == OP_MUL) begin
            mcand   <= rd0_data;
            mplier  <= rd1_data;
            acc     <= '0;
            mul_cnt <= '0;
          end else begin
            wr_addr <= rd;
            wr_data <= alu_result;
          end
        end
        EXEC: begin
          acc     <= acc_step;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          mul_cnt <= mul_cnt + 1'b1;
          if (mul_cnt == CNT_LAST) begin
            wr_addr <= rd;
            wr_data <= acc_step;
          end
        end
        WB: retired <= retired + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/exec_wb_stage.md
Name: exec_wb_stage

Overview:
- Single-issue execute/writeback stage that feeds the 8 x 16-bit register file.
- Accepts one 16-bit instruction at a time through a valid/ready handshake.
- Drives the register file read addresses and captures the returned operands.
- Computes the result (including an iterative 16-cycle multiply) and issues exactly one write per instruction.

Parameters:
- DATA_W, 16, operand/result width; must match the register file word.
- ADDR_W, 3, register address width (8 registers).
- MUL_CYCLES, 16, multiply iterations; must equal DATA_W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (asserted at 0)
- instr_valid  in  1  upstream instruction valid
- instr_ready  out  1  stage can accept an instruction
- instr  in  16  op[15:13] rd[12:10] rs0[9:7] rs1[6:4] imm4[3:0]
- rd0_addr  out  ADDR_W  register file read port 0 address (rs0)
- rd1_addr  out  ADDR_W  register file read port 1 address (rs1)
- rd0_data  in  DATA_W  register file read port 0 data (combinational)
- rd1_data  in  DATA_W  register file read port 1 data (combinational)
- RegWrite  out  1  register file write enable
- wr_addr  out  ADDR_W  register file write address
- wr_data  out  DATA_W  register file write data
- busy  out  1  high whenever the state is not IDLE
- retired  out  16  count of completed writebacks; wraps at 65535 -> 0

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; RegWrite=0; wr_addr=0; wr_data=0; rd0_addr=0; rd1_addr=0; retired=0; busy=0.
  - Any in-flight instruction is discarded with no write.
  - instr_ready=1 once rst=1.
- instr_ready = (state==IDLE). The instruction is accepted on the rising edge where instr_valid && instr_ready; instr is latched into an internal register.
- States:
  - IDLE: wait for accept -> READ.
  - READ, 1 cycle: rd0_addr=rs0, rd1_addr=rs1 (registered from the latched instr, stable for the whole cycle). rd0_data/rd1_data are captured at the end of the cycle. Go to EXEC if op==MUL, else WB with the result computed.
  - EXEC: shift-add multiply, one partial-product step per cycle, MUL_CYCLES cycles, then WB.
  - WB, 1 cycle: RegWrite=1, wr_addr=rd, wr_data=result. retired increments at the end of WB. Next state is IDLE.
- RegWrite is high only in WB, for exactly one cycle per instruction.
- Latency from the accept edge:
  - ALU ops: RegWrite high 2 cycles later (IDLE-READ-WB-IDLE); one instruction per 3 cycles.
  - MUL: RegWrite high 18 cycles later; one instruction per 19 cycles.
- Ops (all results truncated to 16 bits, no flags, no overflow detection):
  - 000 ADD: a+b
  - 001 SUB: a-b (two's complement)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLL: a << b[3:0]; b[15:4] is ignored
  - 110 MUL: low 16 bits of unsigned a*b
  - 111 ADDI: a + sign-extended imm4 (range -8..+7); rs1 is ignored
- Hazards: none possible. The register file is written at the end of WB, and the next instruction's READ occurs no earlier than 2 cycles later, so it sees the updated value.
- rd==rs0 or rd==rs1 is legal; the old operand value is used.
- No hardwired zero register; writes to r0 are performed.
- instr_valid while busy: ignored, not latched. The upstream block must hold instr until it is accepted.
- Reset asserted mid-EXEC or in WB: no write occurs after reset is asserted, and the state returns to IDLE.
- wr_addr/wr_data hold their last WB values outside WB; only RegWrite qualifies them.

Test Plan:
- Reset, then r1=0x0005, r2=0x0003 preset in the register file. ADD r3,r1,r2 -> RegWrite high exactly 2 cycles after accept, wr_addr=3, wr_data=0x0008; retired=1.
- SUB r4,r2,r1 -> wr_data=0xFFFE. ADDI r5,r1,imm4=0xF -> wr_data=0x0004.
- MUL r6,r1,r2 -> busy for 18 cycles, RegWrite in cycle 18 with wr_data=0x000F. MUL 0xFFFF*0x0002 -> 0xFFFE.
- Hold instr_valid=1 with back-to-back ADDs -> accepts spaced exactly 3 cycles apart; no extra writes; the second ADD reading the first ADD's rd sees the new value.
- Assert rst=0 at cycle 8 of a MUL -> RegWrite never asserts; after release, instr_ready=1 and retired=0.
- SLL r7,r1,r2 with r2=0x0013 -> shift by 3, wr_data=0x0028. Write to r0 -> r0 is updated.
